sc_note_metadata_server: RTL and testbench
==========================================

Name: sc_note_metadata_server

Overview:
Supplier end of the per-lane note-metadata handshake used by the note matchers. It streams a time-sorted song chart from a synchronous-read chart memory and keeps one pending note time per lane. Each lane's slot is presented as metadata_link/metadata_available. When a lane's matcher consumes its slot by pulsing metadata_request, the server refills that slot with the lane's next chart entry.

Parameters:
NUM_LANES, 37, number of note lanes / slots
TIME_W, 16, note time width (matches song_time)
ADDR_W, 12, chart memory address width
LANE_W, 6, lane index field width in a chart entry

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin streaming the chart from address 0
chart_len  in  ADDR_W  number of valid chart entries (0 allowed)
song_time  in  TIME_W  current song time (used only with SC_STALE_DROP_EN)
chart_addr  out  ADDR_W  chart memory read address
chart_rd  out  1  chart memory read strobe
chart_data  in  LANE_W+TIME_W  entry {lane, time}, valid 1 cycle after chart_rd
metadata_request  in  NUM_LANES  per-lane consume pulse from matchers
metadata_link  out  NUM_LANES*TIME_W  per-lane note time; lane k at [k*TIME_W +: TIME_W]
metadata_available  out  NUM_LANES  per-lane slot-valid flags
busy  out  1  streaming in progress
done  out  1  sticky: all entries placed or dropped
bad_lane  out  1  sticky: an entry had lane >= NUM_LANES

Behaviour:
- Reset (async, rst_n=0): state IDLE; chart_addr=0; chart_rd=0; metadata_link=0; metadata_available=0; busy=0; done=0; bad_lane=0. A reset asserted mid-stream aborts the stream and clears all slots immediately.
- FSM states: IDLE, FETCH, WAIT, PLACE.
- IDLE: on start, ptr<=0, done<=0, bad_lane<=0, all slots cleared.
  - If chart_len==0: done<=1 and stay in IDLE.
  - Otherwise busy<=1 and go to FETCH.
  - start is ignored in any state other than IDLE.
- FETCH: chart_rd=1 for one cycle with chart_addr=ptr; go to WAIT.
- WAIT: one cycle for the memory read latency; chart_data is captured into an entry register at the end of this cycle; go to PLACE.
- PLACE: let L = lane field of the entry and T = time field.
  - If L >= NUM_LANES: set bad_lane and skip the entry.
  - Else if slot L is empty and metadata_request[L]=0: link[L]<=T, available[L]<=1; entry is consumed.
  - Else stall in PLACE. Ordering is strictly preserved: a blocked entry blocks the whole stream.
  - After a consume or skip: ptr<=ptr+1. If ptr+1 == chart_len: busy<=0, done<=1, go to IDLE. Otherwise go to FETCH.
  - Fill throughput: one entry per 3 cycles when nothing is blocked.
- Handshake, any state:
  - metadata_request[k]=1 while available[k]=1 clears available[k] on the next edge. link[k] holds its last value.
  - A request on an empty slot is ignored.
  - If a request and a PLACE targeting the same lane occur in the same cycle, the request wins and the load happens the following cycle. A slot is never loaded and cleared on the same edge.
- Latency:
  - start to the first slot available: 4 cycles (IDLE→FETCH→WAIT→PLACE, with the load at the end of PLACE).
  - Refill after a consume unblocks a stalled entry: available 2 cycles after the request edge.
- Width rules: ptr is ADDR_W bits with no wrap; chart_len ≥ 2^ADDR_W is unsupported. Times are copied unmodified.

Optional Feature:
Macro SC_STALE_DROP_EN.
- Defined: in PLACE, a valid-lane entry with T < song_time (unsigned compare) is dropped instead of placed or stalled, and ptr advances. An already-loaded slot is never dropped. This prevents missed notes from stalling the chart.
- Not defined: song_time is unused and every valid entry is eventually placed.

Test Plan:
1. Reset mid-stream (rst_n=0 while in PLACE with slots 0 and 5 loaded) -> all outputs 0 immediately; after release, state IDLE and done=0.
2. Chart {(0,100),(1,120),(36,150)}, chart_len=3, start -> available[0] set 4 cycles after start; link[0]=100, link[1]=120, link[36]=150; done=1, busy=0 after the 3rd placement.
3. Chart {(2,50),(2,80),(3,90)} -> lane 2 shows 50; stream stalls and available[3] stays 0 until request[2] pulses; then link[2]=80 two cycles after the request edge, then link[3]=90.
4. Same-cycle collision: request[2]=1 in the PLACE cycle targeting lane 2 -> available[2]=0 for one cycle, then 1 with the new time; never a lost or duplicate load.
5. Entry (40,200) followed by (4,210) -> bad_lane=1, entry skipped, link[4]=210; chart_len=0 with start -> done=1 next cycle, no chart_rd.
6. With SC_STALE_DROP_EN, song_time=300, chart {(6,250),(6,400)} -> 250 dropped, link[6]=400; without the macro -> link[6]=250.

Source files
------------

// File: rtl/sc_note_metadata_server.sv
// Note-metadata supplier: streams a time-sorted chart from synchronous-read memory into one pending slot per lane.
// Optional build macro SC_STALE_DROP_EN: entries already older than song_time are dropped instead of placed.
module sc_note_metadata_server #(
  parameter int NUM_LANES = 37,
  parameter int TIME_W    = 16,
  parameter int ADDR_W    = 12,
  parameter int LANE_W    = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           chart_len,
  input  logic [TIME_W-1:0]           song_time,
  output logic [ADDR_W-1:0]           chart_addr,
  output logic                        chart_rd,
  input  logic [LANE_W+TIME_W-1:0]    chart_data,
  input  logic [NUM_LANES-1:0]        metadata_request,
  output logic [NUM_LANES*TIME_W-1:0] metadata_link,
  output logic [NUM_LANES-1:0]        metadata_available,
  output logic                        busy,
  output logic                        done,
  output logic                        bad_lane
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_PLACE
  } state_t;

  localparam logic [LANE_W:0] LP_NUM_LANES = (LANE_W + 1)'(NUM_LANES);

  state_t                             r_state;
  logic [ADDR_W-1:0]                  r_ptr;
  logic [ADDR_W-1:0]                  r_chart_addr;
  logic                               r_chart_rd;
  logic [LANE_W+TIME_W-1:0]           r_entry;
  logic [NUM_LANES-1:0][TIME_W-1:0]   r_link;
  logic [NUM_LANES-1:0]               r_avail;
  logic                               r_busy;
  logic                               r_done;
  logic                               r_bad_lane;

  logic [LANE_W-1:0]                  w_lane;
  logic [TIME_W-1:0]                  w_time;
  logic                               w_lane_ok;
  logic [LANE_W-1:0]                  w_idx;
  logic                               w_slot_free;
  logic                               w_stale;
  logic                               w_advance;
  logic                               w_load;
  logic [ADDR_W-1:0]                  w_ptr_nxt;

  assign w_lane    = r_entry[LANE_W+TIME_W-1 -: LANE_W];
  assign w_time    = r_entry[TIME_W-1:0];
  assign w_lane_ok = ({1'b0, w_lane} < LP_NUM_LANES);
  assign w_ptr_nxt = r_ptr + ADDR_W'(1);

`ifdef SC_STALE_DROP_EN
  assign w_stale = w_lane_ok && (w_time < song_time);
`else
  logic w_unused_song_time;
  assign w_unused_song_time = ^song_time;
  assign w_stale = 1'b0;
`endif

  // A pending request on the target lane blocks the load for this cycle so a
  // slot is never loaded and cleared on the same edge.
  always_comb begin
    w_idx       = '0;
    w_slot_free = 1'b0;
    if (w_lane_ok) begin
      w_idx       = w_lane;
      w_slot_free = !r_avail[w_idx] && !metadata_request[w_idx];
    end
    w_load    = w_lane_ok && !w_stale && w_slot_free;
    w_advance = !w_lane_ok || w_stale || w_slot_free;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_chart_addr <= '0;
      r_chart_rd   <= 1'b0;
      r_entry      <= '0;
      r_link       <= '0;
      r_avail      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_bad_lane   <= 1'b0;
    end else begin
      r_avail    <= r_avail & ~metadata_request;
      r_chart_rd <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_ptr      <= '0;
            r_done     <= 1'b0;
            r_bad_lane <= 1'b0;
            r_avail    <= '0;
            if (chart_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_busy       <= 1'b1;
              r_chart_rd   <= 1'b1;
              r_chart_addr <= '0;
              r_state      <= ST_FETCH;
            end
          end
        end
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_entry <= chart_data;
          r_state <= ST_PLACE;
        end
        ST_PLACE: begin
          if (!w_lane_ok) r_bad_lane <= 1'b1;
          if (w_load) begin
            r_link[w_idx]  <= w_time;
            r_avail[w_idx] <= 1'b1;
          end
          if (w_advance) begin
            r_ptr <= w_ptr_nxt;
            if (w_ptr_nxt == chart_len) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_chart_rd   <= 1'b1;
              r_chart_addr <= w_ptr_nxt;
              r_state      <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign chart_addr         = r_chart_addr;
  assign chart_rd           = r_chart_rd;
  assign metadata_link      = r_link;
  assign metadata_available = r_avail;
  assign busy               = r_busy;
  assign done               = r_done;
  assign bad_lane           = r_bad_lane;

endmodule

// File: tb/tb_sc_note_metadata_server.sv
// Directed bench for sc_note_metadata_server with a small synchronous-read chart memory model.
module tb_sc_note_metadata_server;

  localparam int NL = 37;
  localparam int TW = 16;
  localparam int AW = 12;
  localparam int LW = 6;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     chart_len;
  logic [TW-1:0]     song_time;
  logic [AW-1:0]     chart_addr;
  logic              chart_rd;
  logic [LW+TW-1:0]  chart_data;
  logic [NL-1:0]     request;
  logic [NL*TW-1:0]  link;
  logic [NL-1:0]     avail;
  logic              busy;
  logic              done;
  logic              bad_lane;

  logic [LW+TW-1:0]  mem [0:15];
  int                n_checks = 0;
  int                n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (chart_rd) chart_data <= mem[chart_addr[3:0]];

  sc_note_metadata_server #(
    .NUM_LANES(NL), .TIME_W(TW), .ADDR_W(AW), .LANE_W(LW)
  ) u_dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .chart_len          (chart_len),
    .song_time          (song_time),
    .chart_addr         (chart_addr),
    .chart_rd           (chart_rd),
    .chart_data         (chart_data),
    .metadata_request   (request),
    .metadata_link      (link),
    .metadata_available (avail),
    .busy               (busy),
    .done               (done),
    .bad_lane           (bad_lane)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] lane_time(input int k);
    return link[k*TW +: TW];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; request = '0; song_time = '0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic set_entry(input int i, input int lane, input int t);
    mem[i] = {LW'(lane), TW'(t)};
  endtask

  // Leaves the bench at the negedge after the start edge (state FETCH).
  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    chart_len = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    do_reset();
    check("rst_avail", 64'(avail), 64'd0);
    check("rst_done", 64'(done), 64'd0);

    // 1: reset mid-stream while third entry sits in PLACE
    set_entry(0, 0, 11); set_entry(1, 5, 22); set_entry(2, 7, 33);
    chart_len = 3;
    pulse_start();
    tick(8);
    check("t1_slot0", 64'(avail[0]), 64'd1);
    check("t1_slot5", 64'(avail[5]), 64'd1);
    check("t1_addr_pre", 64'(chart_addr), 64'd2);
    rst_n = 1'b0;
    #1;
    check("t1_avail0", 64'(avail), 64'd0);
    check("t1_link0", 64'(lane_time(0) | lane_time(5)), 64'd0);
    check("t1_busy0", 64'(busy), 64'd0);
    check("t1_addr0", 64'(chart_addr), 64'd0);
    check("t1_rd0", 64'(chart_rd), 64'd0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    check("t1_done_after", 64'(done), 64'd0);
    check("t1_idle_rd", 64'(chart_rd), 64'd0);
    check("t1_idle_busy", 64'(busy), 64'd0);

    // 2: three entries, first available 4 cycles after start
    do_reset();
    set_entry(0, 0, 100); set_entry(1, 1, 120); set_entry(2, 36, 150);
    chart_len = 3;
    pulse_start();
    check("t2_rd_fetch", 64'(chart_rd), 64'd1);
    check("t2_busy", 64'(busy), 64'd1);
    tick(2);
    check("t2_avail0_early", 64'(avail[0]), 64'd0);
    tick(1);
    check("t2_avail0", 64'(avail[0]), 64'd1);
    check("t2_link0", 64'(lane_time(0)), 64'd100);
    tick(3);
    check("t2_link1", 64'(lane_time(1)), 64'd120);
    check("t2_avail1", 64'(avail[1]), 64'd1);
    tick(2);
    check("t2_done_early", 64'(done), 64'd0);
    tick(1);
    check("t2_link36", 64'(lane_time(36)), 64'd150);
    check("t2_avail36", 64'(avail[36]), 64'd1);
    check("t2_done", 64'(done), 64'd1);
    check("t2_busy_end", 64'(busy), 64'd0);

    // 3: blocked lane stalls the whole stream until consumed
    do_reset();
    set_entry(0, 2, 50); set_entry(1, 2, 80); set_entry(2, 3, 90);
    chart_len = 3;
    pulse_start();
    tick(3);
    check("t3_link2_a", 64'(lane_time(2)), 64'd50);
    tick(6);
    check("t3_stall_avail3", 64'(avail[3]), 64'd0);
    check("t3_stall_link2", 64'(lane_time(2)), 64'd50);
    check("t3_stall_busy", 64'(busy), 64'd1);
    request[2] = 1'b1;
    tick(1);
    request = '0;
    check("t3_cleared", 64'(avail[2]), 64'd0);
    check("t3_link_held", 64'(lane_time(2)), 64'd50);
    tick(1);
    check("t3_refill_avail", 64'(avail[2]), 64'd1);
    check("t3_refill_link", 64'(lane_time(2)), 64'd80);
    tick(4);
    check("t3_link3", 64'(lane_time(3)), 64'd90);
    check("t3_avail3", 64'(avail[3]), 64'd1);
    check("t3_done", 64'(done), 64'd1);

    // 4: request and PLACE on the same lane in the same cycle
    do_reset();
    set_entry(0, 2, 10); set_entry(1, 2, 20);
    chart_len = 2;
    pulse_start();
    tick(3);
    check("t4_first", 64'(lane_time(2)), 64'd10);
    tick(2);
    request[2] = 1'b1;
    tick(1);
    request = '0;
    check("t4_gap_avail", 64'(avail[2]), 64'd0);
    check("t4_gap_link", 64'(lane_time(2)), 64'd10);
    tick(1);
    check("t4_load_avail", 64'(avail[2]), 64'd1);
    check("t4_load_link", 64'(lane_time(2)), 64'd20);
    check("t4_done", 64'(done), 64'd1);
    tick(1);
    check("t4_no_dup_rd", 64'(chart_rd), 64'd0);
    check("t4_still_avail", 64'(avail[2]), 64'd1);

    // 5: out-of-range lane skipped, then empty chart
    do_reset();
    set_entry(0, 40, 200); set_entry(1, 4, 210);
    chart_len = 2;
    pulse_start();
    tick(3);
    check("t5_bad", 64'(bad_lane), 64'd1);
    check("t5_bad_noload", 64'(avail), 64'd0);
    tick(3);
    check("t5_link4", 64'(lane_time(4)), 64'd210);
    check("t5_avail4", 64'(avail[4]), 64'd1);
    check("t5_done", 64'(done), 64'd1);
    chart_len = 0;
    pulse_start();
    check("t5_len0_bad_clr", 64'(bad_lane), 64'd0);
    check("t5_len0_avail_clr", 64'(avail), 64'd0);
    check("t5_len0_rd", 64'(chart_rd), 64'd0);
    do_reset();
    check("t5_rst_done", 64'(done), 64'd0);
    pulse_start();
    check("t5_len0_done", 64'(done), 64'd1);
    check("t5_len0_busy", 64'(busy), 64'd0);
    check("t5_len0_rd2", 64'(chart_rd), 64'd0);

    // 6: stale entry handling depends on build
    do_reset();
    song_time = 16'd300;
    set_entry(0, 6, 250); set_entry(1, 6, 400);
    chart_len = 2;
    pulse_start();
    tick(3);
`ifdef SC_STALE_DROP_EN
    check("t6_dropped", 64'(avail[6]), 64'd0);
    tick(3);
    check("t6_link6", 64'(lane_time(6)), 64'd400);
    check("t6_done", 64'(done), 64'd1);
`else
    check("t6_placed", 64'(avail[6]), 64'd1);
    tick(3);
    check("t6_link6", 64'(lane_time(6)), 64'd250);
    check("t6_stalled", 64'(busy), 64'd1);
`endif
    song_time = '0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
